// File: rtl/alu_accu_seq_pkg.sv
// Shared types for the ALU/accumulator command sequencer.
// State encoding and the latched command record.
package alu_accu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 3;
    localparam int REP_W  = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CAPTURE,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] operand_a;
        logic [DATA_W-1:0] operand_b;
        logic              src_acc;
        logic              use_carry;
        logic [REP_W-1:0]  rep;
    } cmd_t;

endpackage

// File: rtl/alu_accu_sequencer.sv
// Command-side controller for the ALU/accumulator datapath.
// Issues one command (with repeats), captures the result, returns a response.
module alu_accu_sequencer
    import alu_accu_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_W,
    parameter int OPCODE_WIDTH = OPC_W,
    parameter int REPEAT_WIDTH = REP_W,
    parameter int COUNT_WIDTH  = CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
    input  logic [DATA_WIDTH-1:0]   cmd_operand_a,
    input  logic [DATA_WIDTH-1:0]   cmd_operand_b,
    input  logic                    cmd_src_acc,
    input  logic                    cmd_use_carry,
    input  logic [REPEAT_WIDTH-1:0] cmd_repeat,
    output logic                    dp_ce,
    output logic [DATA_WIDTH-1:0]   dp_data_0,
    output logic [DATA_WIDTH-1:0]   dp_data_1,
    output logic [OPCODE_WIDTH-1:0] dp_opcode,
    output logic                    dp_carry_in,
    input  logic [DATA_WIDTH-1:0]   dp_result,
    input  logic                    dp_carry,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic [COUNT_WIDTH-1:0]  op_count,
    output logic                    busy
);

    state_e                  state_q;
    cmd_t                    cmd_q;
    logic [REPEAT_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_carry_q;
    logic                    rsp_zero_q;
    logic [COUNT_WIDTH-1:0]  cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            rem_q       <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.opcode    <= cmd_opcode;
                        cmd_q.operand_a <= cmd_operand_a;
                        cmd_q.operand_b <= cmd_operand_b;
                        cmd_q.src_acc   <= cmd_src_acc;
                        cmd_q.use_carry <= cmd_use_carry;
                        cmd_q.rep       <= cmd_repeat;
                        rem_q           <= cmd_repeat;
                        state_q         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (rem_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        rem_q <= rem_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    rsp_data_q  <= dp_result;
                    rsp_carry_q <= dp_carry;
                    rsp_zero_q  <= (dp_result == '0);
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Operand A may track the live accumulator, so drive from state, not a register.
    always_comb begin
        dp_ce       = 1'b0;
        dp_data_0   = '0;
        dp_data_1   = '0;
        dp_opcode   = '0;
        dp_carry_in = 1'b0;
        if (state_q == S_EXEC) begin
            dp_ce       = 1'b1;
            dp_opcode   = cmd_q.opcode;
            dp_data_1   = cmd_q.operand_b;
            dp_data_0   = cmd_q.src_acc ? dp_result : cmd_q.operand_a;
            dp_carry_in = cmd_q.use_carry & dp_carry;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_accu_sequencer.sv
// Directed-vector bench for alu_accu_sequencer with a behavioural datapath.
// A second instance with a 2-bit counter runs in lockstep for wrap checks.
module tb_alu_accu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd_opcode;
    logic [7:0] cmd_operand_a;
    logic [7:0] cmd_operand_b;
    logic       cmd_src_acc;
    logic       cmd_use_carry;
    logic [3:0] cmd_repeat;
    logic       rsp_ready;

    logic       cmd_ready,   cmd_ready2;
    logic       dp_ce,       dp_ce2;
    logic [7:0] dp_data_0,   dp_data_0b;
    logic [7:0] dp_data_1,   dp_data_1b;
    logic [2:0] dp_opcode,   dp_opcode2;
    logic       dp_carry_in, dp_carry_in2;
    logic [7:0] acc1,        acc2;
    logic       cy1,         cy2;
    logic       rsp_valid,   rsp_valid2;
    logic [7:0] rsp_data,    rsp_data2;
    logic       rsp_carry,   rsp_carry2;
    logic       rsp_zero,    rsp_zero2;
    logic [7:0] op_count;
    logic [1:0] op_count2;
    logic       busy,        busy2;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_accu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_operand_a(cmd_operand_a),
        .cmd_operand_b(cmd_operand_b), .cmd_src_acc(cmd_src_acc),
        .cmd_use_carry(cmd_use_carry), .cmd_repeat(cmd_repeat),
        .dp_ce(dp_ce), .dp_data_0(dp_data_0), .dp_data_1(dp_data_1),
        .dp_opcode(dp_opcode), .dp_carry_in(dp_carry_in),
        .dp_result(acc1), .dp_carry(cy1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .op_count(op_count), .busy(busy)
    );

    alu_accu_sequencer #(.COUNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_opcode(cmd_opcode), .cmd_operand_a(cmd_operand_a),
        .cmd_operand_b(cmd_operand_b), .cmd_src_acc(cmd_src_acc),
        .cmd_use_carry(cmd_use_carry), .cmd_repeat(cmd_repeat),
        .dp_ce(dp_ce2), .dp_data_0(dp_data_0b), .dp_data_1(dp_data_1b),
        .dp_opcode(dp_opcode2), .dp_carry_in(dp_carry_in2),
        .dp_result(acc2), .dp_carry(cy2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .rsp_carry(rsp_carry2), .rsp_zero(rsp_zero2),
        .op_count(op_count2), .busy(busy2)
    );

    // Datapath model: 0=ADD with carry, 1=XOR, 2=AND, others pass B.
    function automatic logic [8:0] alu(logic [2:0] op, logic [7:0] a,
                                       logic [7:0] b, logic ci);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
            3'd1:    return {1'b0, a ^ b};
            3'd2:    return {1'b0, a & b};
            default: return {1'b0, b};
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {cy1, acc1} <= '0;
            {cy2, acc2} <= '0;
        end else begin
            if (dp_ce)
                {cy1, acc1} <= alu(dp_opcode, dp_data_0, dp_data_1, dp_carry_in);
            if (dp_ce2)
                {cy2, acc2} <= alu(dp_opcode2, dp_data_0b, dp_data_1b, dp_carry_in2);
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       src;
        logic       uc;
        logic [3:0] rep;
        logic [7:0] ed;
        logic       ec;
        logic       ez;
    } vec_t;

    vec_t vt[10];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(vec_t v, int hold);
        int k;
        int ce_n;
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_opcode    = v.op;
        cmd_operand_a = v.a;
        cmd_operand_b = v.b;
        cmd_src_acc   = v.src;
        cmd_use_carry = v.uc;
        cmd_repeat    = v.rep;
        rsp_ready     = (hold == 0);
        cmd_valid     = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1;
        ce_n = 0;
        while (!rsp_valid && k < 60) begin
            ce_n += int'(dp_ce);
            @(negedge clk);
            k++;
        end
        chk("rsp_latency", k, int'(v.rep) + 3);
        chk("ce_cycles", ce_n, int'(v.rep) + 1);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, v.ed});
        chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.ec});
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.ez});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_hold",
                {rsp_valid, cmd_ready, dp_ce, rsp_data, rsp_carry, rsp_zero},
                {1'b1, 1'b0, 1'b0, v.ed, v.ec, v.ez});
        end
        rsp_ready = 1'b1;
        exp_cnt++;
        @(negedge clk);
        chk("idle_after_rsp", {busy, rsp_valid, cmd_ready}, 3'b001);
        chk("op_count", {24'd0, op_count}, exp_cnt & 32'hFF);
        chk("op_count_w2", {30'd0, op_count2}, exp_cnt & 32'h3);
    endtask

    initial begin
        int seen;
        vec_t bp;
        vec_t rv;
        vt[0] = '{3'd0, 8'h12, 8'h34, 1'b0, 1'b0, 4'd0,  8'h46, 1'b0, 1'b0};
        vt[1] = '{3'd0, 8'h05, 8'h00, 1'b0, 1'b0, 4'd0,  8'h05, 1'b0, 1'b0};
        vt[2] = '{3'd0, 8'h00, 8'h03, 1'b1, 1'b0, 4'd3,  8'h11, 1'b0, 1'b0};
        vt[3] = '{3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b1};
        vt[4] = '{3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 4'd0,  8'h01, 1'b0, 1'b0};
        vt[5] = '{3'd0, 8'h80, 8'h80, 1'b0, 1'b1, 4'd2,  8'h01, 1'b1, 1'b0};
        vt[6] = '{3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0, 4'd0,  8'hCC, 1'b0, 1'b0};
        vt[7] = '{3'd0, 8'h00, 8'h01, 1'b1, 1'b0, 4'd15, 8'hDC, 1'b0, 1'b0};
        vt[8] = '{3'd0, 8'h00, 8'h30, 1'b1, 1'b0, 4'd1,  8'h3C, 1'b0, 1'b0};
        vt[9] = '{3'd2, 8'h00, 8'hFF, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_opcode = '0;
        cmd_operand_a = '0;
        cmd_operand_b = '0;
        cmd_src_acc = 1'b0;
        cmd_use_carry = 1'b0;
        cmd_repeat = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outputs",
            {busy, rsp_valid, dp_ce, cmd_ready, rsp_carry, rsp_zero},
            6'b000100);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);
        chk("rst_dp_out", {dp_data_0, dp_data_1, dp_opcode, dp_carry_in}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_cmd(vt[i], 0);

        bp = '{3'd0, 8'h01, 8'h02, 1'b0, 1'b0, 4'd0, 8'h03, 1'b0, 1'b0};
        run_cmd(bp, 10);

        // Reset in the third EXEC cycle of a repeat-7 command.
        @(negedge clk);
        cmd_opcode = 3'd0;
        cmd_operand_a = 8'h01;
        cmd_operand_b = 8'h01;
        cmd_src_acc = 1'b0;
        cmd_use_carry = 1'b0;
        cmd_repeat = 4'd7;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("exec_before_rst", {busy, dp_ce}, 2'b11);
        rst = 1'b1;
        #1;
        chk("rst_mid_exec", {busy, dp_ce, rsp_valid}, 3'b000);
        chk("rst_mid_count", {24'd0, op_count}, 32'd0);
        exp_cnt = 0;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("cmd_during_rst", {busy, dp_ce}, 2'b00);
        cmd_valid = 1'b0;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1;
        end
        chk("no_rsp_after_rst", seen, 0);
        chk("count_after_rst", {24'd0, op_count}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            rv = '{3'd0, 8'(i), 8'h01, 1'b0, 1'b0, 4'd0, 8'(i + 1), 1'b0, 1'b0};
            run_cmd(rv, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
